// File: rtl/fpga_config_loader.sv
// Streaming bitstream loader: assembles CFG_W-bit column words from IN_W-bit beats,
// walks a one-hot column enable across the fabric, then raises ff_en and rdy.
module fpga_config_loader #(
    parameter int CFG_W     = 320,
    parameter int NCOLS     = 172,
    parameter int IN_W      = 8,
    parameter int FF_DELAY  = 10,
    parameter int RDY_DELAY = 10
) (
    input  logic             clock,
    input  logic             rst,
    input  logic [IN_W-1:0]  s_data,
    input  logic             s_valid,
    output logic             s_ready,
    output logic [CFG_W-1:0] configs_in,
    output logic [NCOLS-1:0] configs_en,
    output logic             ff_en,
    output logic             rdy
);
    localparam int BEATS = CFG_W / IN_W;
    localparam int BW    = (BEATS > 1) ? $clog2(BEATS) : 1;
    localparam int CW    = $clog2(NCOLS + 1);
    localparam int DMAX  = (FF_DELAY > RDY_DELAY) ? FF_DELAY : RDY_DELAY;
    localparam int DW    = $clog2(DMAX + 1);

    localparam logic [2:0] FILL     = 3'd0;
    localparam logic [2:0] COMMIT   = 3'd1;
    localparam logic [2:0] SHIFT    = 3'd2;
    localparam logic [2:0] SETTLE   = 3'd3;
    localparam logic [2:0] WAIT_RDY = 3'd4;
    localparam logic [2:0] DONE     = 3'd5;

    logic [2:0]       state_q, state_d;
    logic [BW-1:0]    beat_q, beat_d;
    logic [CW-1:0]    col_q, col_d;
    logic [DW-1:0]    dly_q, dly_d;
    logic [CFG_W-1:0] asm_q, asm_d;
    logic [CFG_W-1:0] cfg_q, cfg_d;
    logic [NCOLS-1:0] en_q, en_d;
    logic             ff_q, ff_d;
    logic             rdy_q, rdy_d;
    logic             accept;

    // Gated with rst so the port reads 0 in reset yet is already 1 on the first cycle after release.
    assign s_ready    = (state_q == FILL) && rst;
    assign accept     = s_valid && s_ready;
    assign configs_in = cfg_q;
    assign configs_en = en_q;
    assign ff_en      = ff_q;
    assign rdy        = rdy_q;

    always_comb begin
        state_d = state_q;
        beat_d  = beat_q;
        col_d   = col_q;
        dly_d   = dly_q;
        asm_d   = asm_q;
        cfg_d   = cfg_q;
        en_d    = en_q;
        ff_d    = ff_q;
        rdy_d   = rdy_q;
        case (state_q)
            FILL: begin
                if (accept) begin
                    asm_d[int'(beat_q) * IN_W +: IN_W] = s_data;
                    if (beat_q == BW'(BEATS - 1)) begin
                        beat_d  = '0;
                        state_d = COMMIT;
                    end else begin
                        beat_d = beat_q + 1'b1;
                    end
                end
            end
            COMMIT: begin
                cfg_d   = asm_q;
                state_d = SHIFT;
            end
            SHIFT: begin
                en_d    = en_q << 1;
                col_d   = col_q + 1'b1;
                state_d = (col_q == CW'(NCOLS - 1)) ? SETTLE : FILL;
            end
            SETTLE: begin
                if (dly_q == DW'(FF_DELAY - 1)) begin
                    ff_d    = 1'b1;
                    dly_d   = '0;
                    state_d = WAIT_RDY;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            WAIT_RDY: begin
                if (dly_q == DW'(RDY_DELAY - 1)) begin
                    rdy_d   = 1'b1;
                    state_d = DONE;
                end else begin
                    dly_d = dly_q + 1'b1;
                end
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock or negedge rst) begin
        if (!rst) begin
            state_q <= FILL;
            beat_q  <= '0;
            col_q   <= '0;
            dly_q   <= '0;
            asm_q   <= '0;
            cfg_q   <= '0;
            en_q    <= NCOLS'(1);
            ff_q    <= 1'b0;
            rdy_q   <= 1'b0;
        end else begin
            state_q <= state_d;
            beat_q  <= beat_d;
            col_q   <= col_d;
            dly_q   <= dly_d;
            asm_q   <= asm_d;
            cfg_q   <= cfg_d;
            en_q    <= en_d;
            ff_q    <= ff_d;
            rdy_q   <= rdy_d;
        end
    end
endmodule

// File: tb/tb_fpga_config_loader.sv
// Bench for fpga_config_loader: vector table for the first column plus an event-scheduled
// reference model checked every cycle under directed and random streams.
module tb_fpga_config_loader;
    localparam int CFG_W     = 320;
    localparam int NCOLS     = 172;
    localparam int IN_W      = 8;
    localparam int FF_DELAY  = 10;
    localparam int RDY_DELAY = 10;
    localparam int BEATS     = CFG_W / IN_W;
    localparam int LOAD_CYCLES = NCOLS * (BEATS + 2);
    localparam logic [NCOLS-1:0] EN0 = NCOLS'(1);

    logic             clock = 1'b0;
    logic             rst   = 1'b1;
    logic [IN_W-1:0]  s_data = '0;
    logic             s_valid = 1'b0;
    logic             s_ready;
    logic [CFG_W-1:0] configs_in;
    logic [NCOLS-1:0] configs_en;
    logic             ff_en;
    logic             rdy;

    always #5 clock = ~clock;

    fpga_config_loader #(
        .CFG_W(CFG_W), .NCOLS(NCOLS), .IN_W(IN_W), .FF_DELAY(FF_DELAY), .RDY_DELAY(RDY_DELAY)
    ) dut (
        .clock(clock), .rst(rst), .s_data(s_data), .s_valid(s_valid), .s_ready(s_ready),
        .configs_in(configs_in), .configs_en(configs_en), .ff_en(ff_en), .rdy(rdy)
    );

    int n_pass = 0;
    int n_total = 0;
    int mode = 0;

    // Reference model: accepted bytes collected in a queue, output changes scheduled by edge number.
    logic [7:0]       m_beats[$];
    logic [CFG_W-1:0] m_word, m_cfg;
    logic [NCOLS-1:0] m_en;
    logic             m_ready, m_ff, m_rdy;
    int m_col, m_words, cyc, t_commit, t_shift, t_ff, t_rdy;
    int dut_t_en0, dut_t_ff, dut_t_rdy;

    function automatic void model_reset();
        m_beats.delete();
        m_word = '0; m_cfg = '0; m_en = EN0;
        m_ready = 1'b1; m_ff = 1'b0; m_rdy = 1'b0;
        m_col = 0; m_words = 0; cyc = 0;
        t_commit = -1; t_shift = -1; t_ff = -1; t_rdy = -1;
        dut_t_en0 = -1; dut_t_ff = -1; dut_t_rdy = -1;
    endfunction

    function automatic void model_edge(logic v, logic [7:0] d);
        cyc++;
        if (v && m_ready) begin
            m_beats.push_back(d);
            if (m_beats.size() == BEATS) begin
                for (int i = 0; i < BEATS; i++) m_word[i*IN_W +: IN_W] = m_beats[i];
                m_beats.delete();
                m_words++;
                m_ready  = 1'b0;
                t_commit = cyc + 1;
                t_shift  = cyc + 2;
            end
        end
        if (cyc == t_commit) m_cfg = m_word;
        if (cyc == t_shift) begin
            m_col++;
            m_en = (m_col < NCOLS) ? (EN0 << m_col) : '0;
            if (m_col == NCOLS) begin
                t_ff  = cyc + FF_DELAY;
                t_rdy = t_ff + RDY_DELAY;
            end else begin
                m_ready = 1'b1;
            end
        end
        if (cyc == t_ff)  m_ff  = 1'b1;
        if (cyc == t_rdy) m_rdy = 1'b1;
    endfunction

    task automatic pick_inputs();
        case (mode)
            0: begin s_valid = 1'b1; s_data = 8'(m_words); end
            1: begin s_valid = ($urandom_range(0, 3) != 0); s_data = 8'($urandom); end
            2: s_data = 8'(m_beats.size());
            3: begin s_valid = 1'b1; s_data = 8'hFF; end
            default: begin s_valid = ~s_valid; s_data = 8'($urandom); end
        endcase
    endtask

    task automatic cmp_out(string name, logic e_ready, logic [CFG_W-1:0] e_cfg,
                           logic [NCOLS-1:0] e_en, logic e_ff, logic e_rdy);
        n_total++;
        if (s_ready === e_ready && configs_in === e_cfg && configs_en === e_en &&
            ff_en === e_ff && rdy === e_rdy) begin
            n_pass++;
        end else begin
            $display("FAIL %s cyc=%0d got s_ready=%b ff=%b rdy=%b en=%h cfg=%h | want s_ready=%b ff=%b rdy=%b en=%h cfg=%h",
                     name, cyc, s_ready, ff_en, rdy, configs_en, configs_in,
                     e_ready, e_ff, e_rdy, e_en, e_cfg);
        end
    endtask

    task automatic check_int(string name, int got, int want);
        n_total++;
        if (got == want) n_pass++;
        else $display("FAIL %s got=%0d want=%0d", name, got, want);
    endtask

    task automatic step();
        @(posedge clock);
        model_edge(s_valid, s_data);
        #1;
        pick_inputs();
        #1;
        cmp_out("cycle", m_ready, m_cfg, m_en, m_ff, m_rdy);
        n_total++;
        if ($countones(configs_en) <= 1) n_pass++;
        else $display("FAIL onehot cyc=%0d got en=%h want popcount<=1", cyc, configs_en);
        if (configs_en == '0 && dut_t_en0 < 0) dut_t_en0 = cyc;
        if (ff_en === 1'b1 && dut_t_ff < 0)    dut_t_ff  = cyc;
        if (rdy === 1'b1 && dut_t_rdy < 0)     dut_t_rdy = cyc;
    endtask

    // Asynchronous reset between edges, immediate check, then release just after an edge.
    task automatic reset_and_check(string tag);
        #1 rst = 1'b0;
        #1 cmp_out(tag, 1'b0, '0, EN0, 1'b0, 1'b0);
        s_valid = 1'b0;
        repeat (2) @(posedge clock);
        #1 rst = 1'b1;
        model_reset();
        pick_inputs();
        #1;
    endtask

    typedef struct {
        int         n;
        logic       valid;
        logic       e_ready;
        int         e_col;
        logic [7:0] e_lo;
        logic [7:0] e_hi;
    } vec_t;

    vec_t tbl[6];
    logic [CFG_W-1:0] w0;
    int guard;

    initial begin
        tbl[0] = '{39, 1'b1, 1'b1, 0, 8'h00, 8'h00};
        tbl[1] = '{1,  1'b1, 1'b0, 0, 8'h00, 8'h00};
        tbl[2] = '{1,  1'b1, 1'b0, 0, 8'h00, 8'h27};
        tbl[3] = '{1,  1'b1, 1'b1, 1, 8'h00, 8'h27};
        tbl[4] = '{3,  1'b0, 1'b1, 1, 8'h00, 8'h27};
        tbl[5] = '{1,  1'b1, 1'b1, 1, 8'h00, 8'h27};
        for (int i = 0; i < BEATS; i++) w0[i*IN_W +: IN_W] = 8'(i);

        // Single-column handshake, data = beat index
        mode = 2;
        reset_and_check("reset_initial");
        for (int r = 0; r < 6; r++) begin
            s_valid = tbl[r].valid;
            repeat (tbl[r].n) step();
            n_total++;
            if (s_ready === tbl[r].e_ready && configs_en === (EN0 << tbl[r].e_col) &&
                configs_in[7:0] === tbl[r].e_lo && configs_in[CFG_W-1 -: 8] === tbl[r].e_hi &&
                ff_en === 1'b0 && rdy === 1'b0) begin
                n_pass++;
            end else begin
                $display("FAIL vec%0d got s_ready=%b en=%h lo=%h hi=%h want s_ready=%b col=%0d lo=%h hi=%h",
                         r, s_ready, configs_en, configs_in[7:0], configs_in[CFG_W-1 -: 8],
                         tbl[r].e_ready, tbl[r].e_col, tbl[r].e_lo, tbl[r].e_hi);
            end
        end

        // Alternate-cycle valid with random beats through the next word
        mode = 4;
        guard = 0;
        while (m_col < 2 && guard < 300) begin step(); guard++; end
        check_int("gap_word_bound", (guard < 300) ? 1 : 0, 1);

        // Full load, word k filled with byte k, continuous valid
        mode = 0;
        reset_and_check("reset_full");
        guard = 0;
        while (!(m_rdy && cyc >= t_rdy + 2) && guard < LOAD_CYCLES + 100) begin step(); guard++; end
        check_int("full_load_bound", (guard < LOAD_CYCLES + 100) ? 1 : 0, 1);
        check_int("cycles_to_en_zero", dut_t_en0, LOAD_CYCLES);
        check_int("ff_en_rise_cycle", dut_t_ff, LOAD_CYCLES + FF_DELAY);
        check_int("rdy_rise_cycle", dut_t_rdy, LOAD_CYCLES + FF_DELAY + RDY_DELAY);

        // Beats after completion are ignored
        mode = 3;
        pick_inputs();
        repeat (20) step();
        cmp_out("post_done", 1'b0, {BEATS{8'hAB}}, '0, 1'b1, 1'b1);

        // Reset mid-word in column 5
        mode = 0;
        reset_and_check("reset_pre_col5");
        guard = 0;
        while (!(m_col == 5 && m_beats.size() == 20) && guard < 400) begin step(); guard++; end
        check_int("col5_bound", (guard < 400) ? 1 : 0, 1);
        mode = 1;
        reset_and_check("reset_mid_col5");

        // Random-valid full load, then reset in the middle of the settle delay
        guard = 0;
        while (!(m_col == NCOLS && cyc == t_shift + 4) && guard < 30000) begin step(); guard++; end
        check_int("random_load_bound", (guard < 30000) ? 1 : 0, 1);
        check_int("random_ff_before_settle_end", int'(ff_en), 0);
        mode = 2;
        reset_and_check("reset_mid_settle");

        // Clean load afterwards: word 0 is presented while column 0 is selected
        s_valid = 1'b1;
        guard = 0;
        while (!(t_commit >= 0 && cyc == t_commit) && guard < 100) begin step(); guard++; end
        check_int("clean_load_bound", (guard < 100) ? 1 : 0, 1);
        cmp_out("clean_word0_col0", 1'b0, w0, EN0, 1'b0, 1'b0);
        step();
        cmp_out("clean_shift_col1", 1'b1, w0, EN0 << 1, 1'b0, 1'b0);

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule
